button_debounce: RTL

Debounces and synchronises one raw mechanical push-button input and produces a clean level `flag` for the pulse-generator stage directly downstream, which converts it into a single-cycle strobe. The block contains a two-flop synchroniser, a four-state debounce FSM with a shared settle counter, and an optional long-press detector. One instance is used per physical button.

---
 rtl/button_debounce.sv | 131 +++++++++++++
 1 files changed

// File: rtl/button_debounce.sv
// Synchronises and debounces one raw push-button into a clean level flag.
// Optional long-press strobe is built only when BUTTON_DEBOUNCE_LONGPRESS_EN is defined.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 25000000,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic flag,
  output logic long_press
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam longint MAX_CYCLES = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Both counters rely on the terminal compare firing before they could wrap.
  if ((DEBOUNCE_CYCLES < 2) || (LONG_CYCLES < 2) ||
      (MAX_CYCLES - 1 >= (longint'(1) << CNT_W))) begin : g_param_check
    $error("button_debounce: illegal DEBOUNCE_CYCLES/LONG_CYCLES/CNT_W combination");
  end

  logic             r_s1;
  logic             r_btn_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_flag;

  state_t           w_next_state;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_flag_next;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours (the synchroniser depends on it).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_btn_s <= 1'b0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_s1    <= btn_in;
      r_btn_s <= r_s1;
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      r_flag  <= w_flag_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (r_btn_s) begin
          w_next_state = PRESS_WAIT;
          w_cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!r_btn_s)               w_next_state = IDLE;
        else if (r_cnt == DEB_LAST) w_next_state = PRESSED;
        else                        w_cnt_next   = r_cnt + CNT_W'(1);
      end
      PRESSED: begin
        if (!r_btn_s) begin
          w_next_state = RELEASE_WAIT;
          w_cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (r_btn_s)                w_next_state = PRESSED;
        else if (r_cnt == DEB_LAST) w_next_state = IDLE;
        else                        w_cnt_next   = r_cnt + CNT_W'(1);
      end
      default: begin
        w_next_state = IDLE;
        w_cnt_next   = '0;
      end
    endcase
    // Decoding the next state keeps flag aligned with the state register.
    w_flag_next = (w_next_state == PRESSED) || (w_next_state == RELEASE_WAIT);
  end

  assign flag = r_flag;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic [CNT_W-1:0] r_hold;
  logic             r_long_done;
  logic             r_long_press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold       <= '0;
      r_long_done  <= 1'b0;
      r_long_press <= 1'b0;
    end else begin
      r_long_press <= 1'b0;
      if ((r_state == PRESS_WAIT) && (w_next_state == PRESSED)) begin
        r_hold      <= '0;
        r_long_done <= 1'b0;
      end else if (r_state == PRESSED) begin
        // Hold saturates at its terminal value; r_long_done stops a second strobe.
        if (r_hold != LONG_LAST) begin
          r_hold <= r_hold + CNT_W'(1);
        end else if (!r_long_done) begin
          r_long_press <= 1'b1;
          r_long_done  <= 1'b1;
        end
      end
    end
  end

  assign long_press = r_long_press;
`else
  assign long_press = 1'b0;
`endif

endmodule
